// File: rtl/shift_add_mac.sv
// Sequential shift-and-add multiplier with an accumulator and a sticky overflow flag.
// Define MAC_SIGNED_EN for two's-complement operands (sign-magnitude core, sign-extended accumulate).
module shift_add_mac #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 2*WIDTH + 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic                 acc_en_i,
    input  logic                 clear_acc_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o,
    output logic [ACC_W-1:0]     acc_o,
    output logic                 acc_ovf_o
);
    localparam int PW = 2*WIDTH;

    // IDLE wait | LOAD operands | TEST/ADD/SHIFT multiply loop | DONE publish result
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_TEST, S_ADD, S_SHIFT, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  opa_q, opa_d, opb_q, opb_d;
    logic              acc_en_q, acc_en_d;
    logic [PW-1:0]     m_q, m_d, p_q, p_d, product_q, product_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              ovf_q, ovf_d;

    logic [WIDTH-1:0]  mag_a, mag_b;
    logic [PW-1:0]     p_res;
    logic [ACC_W-1:0]  p_ext;
    logic [ACC_W:0]    acc_sum;
    logic              ovf_add;

    assign acc_sum = {1'b0, acc_q} + {1'b0, p_ext};

`ifdef MAC_SIGNED_EN
    logic neg_q, neg_d;

    // The most negative value negates to itself, which read unsigned is 2^(WIDTH-1).
    assign mag_a   = opa_q[WIDTH-1] ? (~opa_q + WIDTH'(1)) : opa_q;
    assign mag_b   = opb_q[WIDTH-1] ? (~opb_q + WIDTH'(1)) : opb_q;
    assign p_res   = neg_q ? (~p_q + PW'(1)) : p_q;
    assign p_ext   = ACC_W'($signed(p_res));
    assign ovf_add = acc_sum[ACC_W] ^ (acc_q[ACC_W-1] ^ p_ext[ACC_W-1] ^ acc_sum[ACC_W-1]);
`else
    assign mag_a   = opa_q;
    assign mag_b   = opb_q;
    assign p_res   = p_q;
    assign p_ext   = ACC_W'(p_res);
    assign ovf_add = acc_sum[ACC_W];
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            opa_q     <= '0;
            opb_q     <= '0;
            acc_en_q  <= 1'b0;
            m_q       <= '0;
            p_q       <= '0;
            q_q       <= '0;
            product_q <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
`ifdef MAC_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            acc_en_q  <= acc_en_d;
            m_q       <= m_d;
            p_q       <= p_d;
            q_q       <= q_d;
            product_q <= product_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
`ifdef MAC_SIGNED_EN
            neg_q     <= neg_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        acc_en_d  = acc_en_q;
        m_d       = m_q;
        p_d       = p_q;
        q_d       = q_q;
        product_d = product_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
`ifdef MAC_SIGNED_EN
        neg_d     = neg_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    opa_d    = a_i;
                    opb_d    = b_i;
                    acc_en_d = acc_en_i;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                m_d     = PW'(mag_a);
                q_d     = mag_b;
                p_d     = '0;
`ifdef MAC_SIGNED_EN
                neg_d   = opa_q[WIDTH-1] ^ opb_q[WIDTH-1];
`endif
                state_d = S_TEST;
            end
            S_TEST: begin
                if (q_q == '0)
                    state_d = S_DONE;
                else if (q_q[0])
                    state_d = S_ADD;
                else
                    state_d = S_SHIFT;
            end
            S_ADD: begin
                p_d     = p_q + m_q;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                m_d     = m_q << 1;
                q_d     = q_q >> 1;
                state_d = S_TEST;
            end
            S_DONE: begin
                product_d = p_res;
                if (acc_en_q) begin
                    acc_d = acc_sum[ACC_W-1:0];
                    if (ovf_add)
                        ovf_d = 1'b1;
                end else begin
                    acc_d = p_ext;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A clear landing on DONE still publishes the fresh result, just never accumulates.
        if (clear_acc_i) begin
            acc_d = (state_q == S_DONE) ? p_ext : '0;
            ovf_d = 1'b0;
        end
    end

    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign product_o = product_q;
    assign acc_o     = acc_q;
    assign acc_ovf_o = ovf_q;

endmodule

// File: doc/shift_add_mac.md
SHIFT_ADD_MAC -- requirements
Module: shift_add_mac

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand width; legal values are 4..32.
REQ-002 Parameter ACC_W, default 2*WIDTH+4, SHALL set the accumulator width; ACC_W >= 2*WIDTH.
REQ-003 clk  input  1  SHALL be the clock; all state updates occur on the rising edge.
REQ-004 reset  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 start  input  1  SHALL request an operation; it is sampled only in IDLE.
REQ-006 acc_en  input  1  SHALL select the accumulate mode: 1 accumulates, 0 overwrites; it is sampled with start.
REQ-007 clear_acc  input  1  SHALL zero the accumulator and the overflow flag.
REQ-008 a  input  WIDTH  SHALL be the multiplicand, sampled with start.
REQ-009 b  input  WIDTH  SHALL be the multiplier, sampled with start.
REQ-010 busy  output  1  SHALL be high in every state except IDLE.
REQ-011 done  output  1  SHALL be a one-cycle pulse, high only in DONE.
REQ-012 product  output  2*WIDTH  SHALL hold the last completed product until the next DONE.
REQ-013 acc  output  ACC_W  SHALL be the accumulator value.
REQ-014 acc_ovf  output  1  SHALL be a sticky accumulator-overflow flag.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, TEST, ADD, SHIFT and DONE.
REQ-016 In IDLE with start=1, the FSM SHALL go to LOAD; otherwise it SHALL stay in IDLE.
REQ-017 LOAD SHALL latch a and b and the acc_en bit, and SHALL perform these register loads:
- M (2*WIDTH bits) <= zero-extended a.
- Q (WIDTH bits) <= b.
- P <= 0.
- The FSM then goes to TEST.
REQ-018 In TEST, the FSM SHALL move as follows:
- Q == 0: go to DONE (early termination).
- Q[0] == 1: go to ADD.
- Otherwise: go to SHIFT.
REQ-019 ADD SHALL perform P <= P + M, modulo 2^(2*WIDTH), and then go to SHIFT.
REQ-020 SHIFT SHALL perform M <= M << 1 and Q <= Q >> 1, and then go to TEST.
REQ-021 DONE SHALL perform these updates in the same cycle, then return to IDLE:
- product <= P.
- acc <= acc_en_latched ? acc + sign/zero-extended P : extended P.
REQ-022 The latency, measured from the edge that samples start to done high, SHALL be 3 + 3*(number of ones in b) + 2*(number of zeros below the MSB one of b), in cycles.
REQ-023 The latency bounds SHALL be: b=0 gives 3 cycles; b=all-ones gives 3*WIDTH+3 cycles.
REQ-024 start while busy SHALL be ignored, with no queuing.
REQ-025 clear_acc in any non-DONE cycle SHALL set acc <= 0 and acc_ovf <= 0.
REQ-026 clear_acc coincident with DONE SHALL set acc <= extended P and acc_ovf <= 0, regardless of acc_en.
REQ-027 acc_ovf SHALL be set on a DONE accumulate in these cases, and SHALL stay set until clear_acc or reset:
- Unsigned build: the add carries out of ACC_W.
- Signed build: the add produces a signed overflow.
- On overflow, acc SHALL wrap.
REQ-028 Inputs a, b and acc_en SHALL be ignored outside the start-sampling cycle.

Reset
REQ-029 reset=0 at a clock edge SHALL force the following values, overriding all other inputs:
- state=IDLE.
- P, M, Q, product and acc cleared to 0.
- acc_ovf=0.
- busy=0 and done=0.
REQ-030 reset asserted mid-operation SHALL abort the operation, and SHALL produce no done pulse and no accumulator update.

Configuration
REQ-031 With the macro MAC_SIGNED_EN defined, operands and results SHALL be treated as two's complement:
- LOAD latches |a| and |b| and neg = a[MSB] ^ b[MSB].
- DONE uses -P when neg=1.
- acc extension is sign extension.
- The most negative operand maps to magnitude 2^(WIDTH-1).
REQ-032 Without MAC_SIGNED_EN, all arithmetic SHALL be unsigned with zero extension, and the signed logic SHALL be absent.

Verification
REQ-033 Reset with start=1 held SHALL keep busy=0, done=0, acc=0 and product=0 until reset deasserts.
REQ-034 WIDTH=8, a=3, b=5, acc_en=0 SHALL give done 11 cycles after start, product=15, acc=15.
REQ-035 WIDTH=8, a=200, b=0 SHALL give done at 3 cycles and product=0; a=255, b=255 SHALL give done at 27 cycles and product=65025.
REQ-036 Two ops with acc_en=1, 10*10 then 20*3, starting from acc=0, SHALL give acc=160; re-pulsing start mid-operation SHALL leave latency and result unchanged.
REQ-037 ACC_W=16, repeated 255*255 accumulates SHALL set acc_ovf on the second DONE; clear_acc SHALL then give acc=0 and acc_ovf=0.
REQ-038 MAC_SIGNED_EN, WIDTH=8: a=-3, b=5 SHALL give product=0xFFF1; a=-128, b=-128 SHALL give product=16384; reset in an ADD cycle SHALL give IDLE with no done.
